// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed shift-add multiplier.
package mult_pkg;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = $clog2(N_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    STEP  = 3'd5
  } state_t;

endpackage

// File: rtl/mult_seq_fsm.sv
// Control FSM and iteration counter for mult_seq_ctrl.
// MULT_SEQ_FAST_EN merges ADD and SHIFT into a single STEP state.
module mult_seq_fsm
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear_load,
  output logic busy,
  output logic done,
  output logic add_sub,
  output logic do_load,
  output logic do_clr,
  output logic do_add,
  output logic do_shift,
  output logic do_step
);

  localparam int CW = $clog2(N);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          last_s;

  assign last_s = (cnt_r == CW'(N - 1));

  // State register and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == CLR) begin
        cnt_r <= {CW{1'b0}};
      end else if ((state_r == SHIFT) || (state_r == STEP)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_load) begin
          state_nxt_s = IDLE;
        end else if (run) begin
          state_nxt_s = CLR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
`ifdef MULT_SEQ_FAST_EN
      CLR:   state_nxt_s = STEP;
`else
      CLR:   state_nxt_s = ADD;
`endif
      ADD:   state_nxt_s = SHIFT;
      SHIFT: state_nxt_s = last_s ? HOLD : ADD;
      STEP:  state_nxt_s = last_s ? HOLD : STEP;
      HOLD: begin
        if (run) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; the last iteration subtracts to weight the multiplier MSB negatively
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    add_sub  = 1'b0;
    do_load  = 1'b0;
    do_clr   = 1'b0;
    do_add   = 1'b0;
    do_shift = 1'b0;
    do_step  = 1'b0;
    case (state_r)
      IDLE: do_load = clear_load;
      CLR: begin
        busy   = 1'b1;
        do_clr = 1'b1;
      end
      ADD: begin
        busy    = 1'b1;
        do_add  = 1'b1;
        add_sub = last_s;
      end
      SHIFT: begin
        busy     = 1'b1;
        do_shift = 1'b1;
      end
      STEP: begin
        busy    = 1'b1;
        do_step = 1'b1;
        add_sub = last_s;
      end
      HOLD: begin
        done    = 1'b1;
        do_load = clear_load;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for an N x N signed shift-add multiplier around an external N+1 bit add/sub unit.
// Optional macro MULT_SEQ_FAST_EN: one add+shift per cycle (N+1 cycle latency).
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Run,
  input  logic         ClearA_LoadB,
  input  logic [N-1:0] S,
  output logic [N:0]   add_a,
  output logic [N:0]   add_b,
  output logic         add_sub,
  input  logic [N:0]   add_s,
  output logic [N-1:0] Aval,
  output logic [N-1:0] Bval,
  output logic         Xval,
  output logic         Busy,
  output logic         Done
);

  logic         x_r;
  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic [N:0]   sum_s;
  logic         do_load_s;
  logic         do_clr_s;
  logic         do_add_s;
  logic         do_shift_s;
  logic         do_step_s;

  mult_seq_fsm #(.N(N)) u_fsm (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .run        (Run),
    .clear_load (ClearA_LoadB),
    .busy       (Busy),
    .done       (Done),
    .add_sub    (add_sub),
    .do_load    (do_load_s),
    .do_clr     (do_clr_s),
    .do_add     (do_add_s),
    .do_shift   (do_shift_s),
    .do_step    (do_step_s)
  );

  assign add_a = {a_r[N-1], a_r};
  assign add_b = {S[N-1], S};
  assign Aval  = a_r;
  assign Bval  = b_r;
  assign Xval  = x_r;

  // Post-add {X,A} value used by the merged step
  always_comb begin
    if (b_r[0]) begin
      sum_s = add_s;
    end else begin
      sum_s = {x_r, a_r};
    end
  end

  // X/A/B datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_r <= 1'b0;
      a_r <= {N{1'b0}};
      b_r <= {N{1'b0}};
    end else if (do_load_s) begin
      x_r <= 1'b0;
      a_r <= {N{1'b0}};
      b_r <= S;
    end else if (do_clr_s) begin
      x_r <= 1'b0;
      a_r <= {N{1'b0}};
    end else if (do_add_s) begin
      if (b_r[0]) begin
        {x_r, a_r} <= add_s;
      end
    end else if (do_shift_s) begin
      a_r <= {x_r, a_r[N-1:1]};
      b_r <= {a_r[0], b_r[N-1:1]};
    end else if (do_step_s) begin
      x_r <= sum_s[N];
      a_r <= sum_s[N:1];
      b_r <= {sum_s[0], b_r[N-1:1]};
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl with a behavioural model of the external add/sub unit.
module tb_mult_seq_ctrl;

`ifdef MULT_SEQ_FAST_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic       x;
    logic [7:0] a;
    logic [7:0] b;
    int         start;
    string      nm;
  } exp_t;

  logic       Clk;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;
  logic [8:0] add_a;
  logic [8:0] add_b;
  logic       add_sub;
  logic [8:0] add_s;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       Xval;
  logic       Busy;
  logic       Done;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  mult_seq_ctrl #(.N(8)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sub      (add_sub),
    .add_s        (add_s),
    .Aval         (Aval),
    .Bval         (Bval),
    .Xval         (Xval),
    .Busy         (Busy),
    .Done         (Done)
  );

  assign add_s = add_sub ? (add_a - add_b) : (add_a + add_b);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endfunction

  task automatic push(string nm, logic x, logic [7:0] a, logic [7:0] b);
    exp_t e;
    e.nm = nm; e.x = x; e.a = a; e.b = b; e.start = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!Done && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (!Done) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: compare the product whenever Done rises
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n && Done && !done_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk({e.nm, "_A"}, 32'(Aval), 32'(e.a));
          chk({e.nm, "_B"}, 32'(Bval), 32'(e.b));
          chk({e.nm, "_X"}, 32'(Xval), 32'(e.x));
          chk({e.nm, "_latency"}, 32'(cyc - e.start), 32'(LAT));
        end
      end
      done_prev = Done;
    end
  end

  initial begin
    Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0; S = 8'h00;
    #1;
    chk("rst_A", 32'(Aval), 32'd0);
    chk("rst_B", 32'(Bval), 32'd0);
    chk("rst_X", 32'(Xval), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_add_sub", 32'(add_sub), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;

    // Load 7, multiply by 59
    @(negedge Clk); S = 8'h07; ClearA_LoadB = 1'b1;
    @(negedge Clk); ClearA_LoadB = 1'b0;
    chk("load_B", 32'(Bval), 32'h07);
    chk("load_A", 32'(Aval), 32'h00);
    S = 8'h3B; Run = 1'b1;
    push("m413", 1'b0, 8'h01, 8'h9D);
    wait_done("m413");

    // Run held high: stays in HOLD with no restart
    repeat (5) @(negedge Clk);
    chk("hold_done", 32'(Done), 32'd1);
    chk("hold_busy", 32'(Busy), 32'd0);
    chk("hold_A", 32'(Aval), 32'h01);
    chk("hold_B", 32'(Bval), 32'h9D);

    // Back-to-back without load: 0x9D (-99) * 2
    Run = 1'b0;
    @(negedge Clk);
    chk("idle_done", 32'(Done), 32'd0);
    S = 8'h02; Run = 1'b1;
    push("m_neg198", 1'b1, 8'hFF, 8'h3A);
    wait_done("m_neg198");
    Run = 1'b0;
    @(negedge Clk);

    // -7 * 59 with ClearA_LoadB and Run dropped mid-run (must be ignored)
    ClearA_LoadB = 1'b1; S = 8'hF9;
    @(negedge Clk); ClearA_LoadB = 1'b0;
    chk("load_B_neg7", 32'(Bval), 32'hF9);
    S = 8'h3B; Run = 1'b1;
    push("m_neg413", 1'b1, 8'hFE, 8'h63);
    repeat (5) @(negedge Clk);
    ClearA_LoadB = 1'b1; Run = 1'b0;
    @(negedge Clk);
    chk("busy_ignore", 32'(Busy), 32'd1);
    ClearA_LoadB = 1'b0; Run = 1'b1;
    wait_done("m_neg413");
    Run = 1'b0;
    @(negedge Clk);

    // -128 * -128
    ClearA_LoadB = 1'b1; S = 8'h80;
    @(negedge Clk); ClearA_LoadB = 1'b0; Run = 1'b1;
    push("m16384", 1'b0, 8'h40, 8'h00);
    wait_done("m16384");
    Run = 1'b0;
    @(negedge Clk);

    // Reset asserted mid-operation, between clock edges
    Run = 1'b1;
    repeat (6) @(negedge Clk);
    chk("mid_busy", 32'(Busy), 32'd1);
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    #1;
    chk("midrst_A", 32'(Aval), 32'd0);
    chk("midrst_B", 32'(Bval), 32'd0);
    chk("midrst_X", 32'(Xval), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    Run = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_done", 32'(Done), 32'd0);
    chk("post_rst_B", 32'(Bval), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencer for an 8x8 signed (two's-complement) shift-add multiplier built around the team's 9-bit combinational add/sub unit.
- Owns the X (sign), A (upper product) and B (multiplier/lower product) registers.
- Drives the adder operands and the subtract select, and sequences 8 add/shift iterations.
- Sits between the board switches/buttons and the hex-display drivers in the lab top level.

Parameters:
N, 8, operand width; adder width is N+1; iteration count is N.

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Run  in  1  level; start multiply (synchronous, already debounced)
ClearA_LoadB  in  1  level; clear X/A, load B from S
S  in  N  multiplicand (switches)
add_a  out  N+1  adder operand A = {A[N-1], A}
add_b  out  N+1  adder operand B = {S[N-1], S}, uncomplemented; the adder inverts internally
add_sub  out  1  1 = adder computes add_a - add_b (it uses this as carry-in)
add_s  in  N+1  adder sum, combinational, same cycle
Aval  out  N  A register
Bval  out  N  B register
Xval  out  1  X register
Busy  out  1  high in CLR/ADD/SHIFT
Done  out  1  high in HOLD

Behaviour:
- Reset (async, Reset_n=0): state IDLE, X=0, A=0, B=0, counter=0, Busy=0, Done=0, add_sub=0.
- IDLE:
  - ClearA_LoadB=1 -> X<=0, A<=0, B<=S; stay IDLE.
  - Else Run=1 -> CLR.
  - ClearA_LoadB has priority over Run in the same cycle.
- CLR (1 cycle): X<=0, A<=0, counter<=0 -> ADD.
- ADD:
  - If B[0]=1: {X,A} <= add_s.
  - If B[0]=0: registers are held.
  - add_sub=1 only when counter==N-1; this handles the negative weight of the multiplier MSB.
  - Next state SHIFT.
- SHIFT: {X,A,B} <= {X, X, A, B[N-1:1]}, an arithmetic right shift with X kept. counter++. Go to HOLD if counter==N-1, else ADD.
- HOLD: Done=1; registers held. Run=0 -> IDLE. ClearA_LoadB is honoured here with the same action as in IDLE.
- Latency: Run sampled in IDLE -> result valid in {A,B} 2N+1 cycles later (17 for N=8). X = sign of the 2N-bit product.
- Run held high through HOLD does not restart; a new multiply needs Run to fall and rise again.
- Run and ClearA_LoadB are ignored while Busy.
- add_a/add_b are driven continuously; add_sub=0 outside ADD at the last iteration.
- Back-to-back runs without a load multiply the current B (previous low product byte) by S. CLR clears A only.
- Reset mid-operation: immediate return to the reset state, no partial result retained.

Optional Feature:
Macro MULT_SEQ_FAST_EN.
- Defined: ADD and SHIFT merge into one state STEP. {X,A,B} shifts using the post-add value (add_s when B[0]=1) in the same cycle. Latency becomes N+1 cycles (9).
- Undefined: separate ADD/SHIFT states as above, 2N+1 cycles.
- Register results are identical in both builds.

Decomposition:
- Package mult_pkg: state enum (IDLE, CLR, ADD, SHIFT, HOLD, STEP), localparam N_DEF=8, counter width $clog2(N).
- Natural sub-module: mult_seq_fsm, holding the state register, counter and decode. The datapath registers stay in mult_seq_ctrl.
- The adder stays external.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle -> Aval=0, Bval=0, Xval=0, Busy=0, Done=0 immediately.
- S=0x07, pulse ClearA_LoadB; S=0x3B, Run=1 -> after 17 cycles Done=1, A=0x01, B=0x9D, X=0 (413).
- B=0xF9 (-7), S=0x3B -> A=0xFE, B=0x63, X=1 (-413).
- B=0x80, S=0x80 (-128*-128) -> A=0x40, B=0x00, X=0 (16384).
- Continue from B=0x9D, no load, S=0x02, Run released then reasserted -> A=0xFF, B=0x3A, X=1 (-198). Run held high -> stays in HOLD, no second multiply.
- Run during the 6th cycle of a multiply, then Reset_n pulse -> all zero, IDLE. ClearA_LoadB while Busy -> B unchanged. MULT_SEQ_FAST_EN build: 7*59 -> same result after 9 cycles.
